// File: rtl/axi_cache_top.sv
// axi_cache_top: AXI4 memory-mapped slave backed by a MEM_DEPTH x 64-bit word
// array. Write and read channels run as independent FSMs sharing one memory
// with a single byte-enabled write port and a single read port (read-first).
// Optional feature macro: AXI_CACHE_DECERR_EN. When it is defined, beats
// addressed at or above MEM_DEPTH*8 are dropped or read as zero and get a
// DECERR response. When it is undefined, upper address bits alias.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// VALID and READY are both 1. VALID never drops before its transfer, and the
// payload driven with VALID is held steady while READY is 0.
module axi_cache_top #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [1:0]                  S_AXI_AWBURST,
  input  logic [2:0]                  S_AXI_AWSIZE,
  input  logic [7:0]                  S_AXI_AWLEN,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WLAST,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [1:0]                  S_AXI_ARBURST,
  input  logic [2:0]                  S_AXI_ARSIZE,
  input  logic [7:0]                  S_AXI_ARLEN,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [1:0]                  dbg_wr_state_o,
  output logic                        dbg_rd_state_o
);

  localparam int IDXW   = $clog2(MEM_DEPTH);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

`ifdef AXI_CACHE_DECERR_EN
  localparam bit DecErrEn = 1'b1;
`else
  localparam bit DecErrEn = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  // AxSIZE carries no information here: every beat is a full 64-bit word.
  logic unused_size;
  assign unused_size = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [IDXW-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
    return a[IDXW+2:3];
  endfunction

  function automatic logic out_of_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return DecErrEn && (|a[AXI_ADDR_WIDTH-1:IDXW+3]);
  endfunction

  // FIXED holds the address; INCR, WRAP and the reserved code all step +8.
  function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input logic [AXI_ADDR_WIDTH-1:0] a,
                                                          input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + AXI_ADDR_WIDTH'(8);
  endfunction

  // Holds both READY outputs low until the first cycle after reset release.
  logic rst_done_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done_q <= 1'b0;
    else        rst_done_q <= 1'b1;
  end

  // ---------------- write path ----------------
  wstate_e                   wstate_q, wstate_d;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q;
  logic [AXI_ID_WIDTH-1:0]   bid_q;
  logic [1:0]                wburst_q, bresp_q;
  logic [7:0]                wlen_q, wcnt_q;
  logic                      slverr_q, decerr_q;
  logic                      aw_hs, w_hs, w_last_beat, slverr_d, decerr_d;
  logic                      awready, wready, bvalid;

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wstate_q <= W_IDLE;
    else        wstate_q <= wstate_d;
  end

  // Write FSM next state, channel readies and handshake strobes.
  always_comb begin
    wstate_d    = wstate_q;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    w_last_beat = (wcnt_q == wlen_q);
    slverr_d    = slverr_q | (S_AXI_WLAST != w_last_beat);
    decerr_d    = decerr_q | out_of_range(waddr_q);
    case (wstate_q)
      W_IDLE: begin
        awready = rst_done_q;
        if (rst_done_q && S_AXI_AWVALID) begin
          aw_hs    = 1'b1;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (S_AXI_WVALID) begin
          w_hs = 1'b1;
          if (w_last_beat) wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (S_AXI_BREADY) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write burst bookkeeping: address, beat count and the sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q  <= '0;
      bid_q    <= '0;
      wburst_q <= 2'b00;
      wlen_q   <= 8'd0;
      wcnt_q   <= 8'd0;
      slverr_q <= 1'b0;
      decerr_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else if (aw_hs) begin
      waddr_q  <= S_AXI_AWADDR;
      bid_q    <= S_AXI_AWID;
      wburst_q <= S_AXI_AWBURST;
      wlen_q   <= S_AXI_AWLEN;
      wcnt_q   <= 8'd0;
      slverr_q <= 1'b0;
      decerr_q <= 1'b0;
    end else if (w_hs) begin
      waddr_q  <= next_addr(waddr_q, wburst_q);
      wcnt_q   <= wcnt_q + 8'd1;
      slverr_q <= slverr_d;
      decerr_q <= decerr_d;
      if (w_last_beat) bresp_q <= decerr_d ? 2'b11 : (slverr_d ? 2'b10 : 2'b00);
    end
  end

  // Byte-enabled memory write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_hs && !out_of_range(waddr_q)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_WSTRB[b]) mem[word_idx(waddr_q)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign S_AXI_AWREADY  = awready;
  assign S_AXI_WREADY   = wready;
  assign S_AXI_BVALID   = bvalid;
  assign S_AXI_BID      = bid_q;
  assign S_AXI_BRESP    = bresp_q;
  assign dbg_wr_state_o = wstate_q;

  // ---------------- read path ----------------
  rstate_e                   rstate_q, rstate_d;
  logic [AXI_ADDR_WIDTH-1:0] raddr_q, r_fetch_addr;
  logic [AXI_ID_WIDTH-1:0]   rid_q;
  logic [1:0]                rburst_q, rresp_q;
  logic [7:0]                rlen_q, rcnt_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, r_fetch_data;
  logic                      rlast_q, r_fetch_oor;
  logic                      ar_hs, r_hs, arready, rvalid;

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rstate_q <= R_IDLE;
    else        rstate_q <= rstate_d;
  end

  // Read FSM next state, channel readies and handshake strobes.
  always_comb begin
    rstate_d = rstate_q;
    arready  = 1'b0;
    rvalid   = 1'b0;
    ar_hs    = 1'b0;
    r_hs     = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready = rst_done_q;
        if (rst_done_q && S_AXI_ARVALID) begin
          ar_hs    = 1'b1;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (S_AXI_RREADY) begin
          r_hs = 1'b1;
          if (rlast_q) rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Word to load into RDATA: the first beat on AR, otherwise the next beat.
  always_comb begin
    r_fetch_addr = ar_hs ? S_AXI_ARADDR : next_addr(raddr_q, rburst_q);
    r_fetch_oor  = out_of_range(r_fetch_addr);
    r_fetch_data = r_fetch_oor ? '0 : mem[word_idx(r_fetch_addr)];
  end

  // Read burst bookkeeping; RDATA is prefetched whenever a beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q  <= '0;
      rid_q    <= '0;
      rburst_q <= 2'b00;
      rlen_q   <= 8'd0;
      rcnt_q   <= 8'd0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
      rlast_q  <= 1'b0;
    end else if (ar_hs) begin
      raddr_q  <= S_AXI_ARADDR;
      rid_q    <= S_AXI_ARID;
      rburst_q <= S_AXI_ARBURST;
      rlen_q   <= S_AXI_ARLEN;
      rcnt_q   <= 8'd0;
      rdata_q  <= r_fetch_data;
      rresp_q  <= r_fetch_oor ? 2'b11 : 2'b00;
      rlast_q  <= (S_AXI_ARLEN == 8'd0);
    end else if (r_hs) begin
      if (rlast_q) begin
        rlast_q <= 1'b0;
      end else begin
        raddr_q <= r_fetch_addr;
        rcnt_q  <= rcnt_q + 8'd1;
        rdata_q <= r_fetch_data;
        rresp_q <= r_fetch_oor ? 2'b11 : 2'b00;
        rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
      end
    end
  end

  assign S_AXI_ARREADY  = arready;
  assign S_AXI_RVALID   = rvalid;
  assign S_AXI_RDATA    = rdata_q;
  assign S_AXI_RID      = rid_q;
  assign S_AXI_RRESP    = rresp_q;
  assign S_AXI_RLAST    = rlast_q;
  assign dbg_rd_state_o = rstate_q;

endmodule

// File: tb/tb_axi_cache_top.sv
// Directed bench for axi_cache_top: single-beat and burst writes/reads,
// strobes, FIXED bursts, backpressure, WLAST errors, address aliasing or
// DECERR (AXI_CACHE_DECERR_EN), and reset in the middle of a read burst.
module tb_axi_cache_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [3:0]  awid = '0, arid = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic [2:0]  awsize = 3'd3, arsize = 3'd3;
  logic [7:0]  awlen = '0, arlen = '0;
  logic        awvalid = 1'b0, arvalid = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;
  logic [1:0]  dbg_wr_state;
  logic        dbg_rd_state;

  int n_tests = 0;
  int n_fail  = 0;

  axi_cache_top dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWID(awid), .S_AXI_AWBURST(awburst),
    .S_AXI_AWSIZE(awsize), .S_AXI_AWLEN(awlen), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARID(arid), .S_AXI_ARBURST(arburst),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARLEN(arlen), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RID(rid), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .dbg_wr_state_o(dbg_wr_state), .dbg_rd_state_o(dbg_rd_state)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One comparison: counts, checks, reports.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [3:0] id,
                         input logic [1:0] burst, input logic [7:0] len);
    int t = 0;
    awaddr = a; awid = id; awburst = burst; awlen = len; awvalid = 1'b1;
    while (!awready && t < 20) begin tick(); t++; end
    chk("awready_wait", 64'(t < 20), 64'd1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
    int t = 0;
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    while (!wready && t < 20) begin tick(); t++; end
    chk("wready_wait", 64'(t < 20), 64'd1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_take(input logic [3:0] eid, input logic [1:0] eresp, input string tag);
    int t = 0;
    bready = 1'b1;
    while (!bvalid && t < 20) begin tick(); t++; end
    chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    chk({tag, "_bid"}, 64'(bid), 64'(eid));
    chk({tag, "_bresp"}, 64'(bresp), 64'(eresp));
    tick();
    bready = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [3:0] id,
                         input logic [1:0] burst, input logic [7:0] len);
    int t = 0;
    araddr = a; arid = id; arburst = burst; arlen = len; arvalid = 1'b1;
    while (!arready && t < 20) begin tick(); t++; end
    chk("arready_wait", 64'(t < 20), 64'd1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic r_take(input logic [63:0] ed, input logic el, input logic [3:0] eid,
                        input logic [1:0] eresp, input string tag);
    int t = 0;
    rready = 1'b1;
    while (!rvalid && t < 20) begin tick(); t++; end
    chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    chk({tag, "_rdata"}, rdata, ed);
    chk({tag, "_rlast"}, 64'(rlast), 64'(el));
    chk({tag, "_rid"}, 64'(rid), 64'(eid));
    chk({tag, "_rresp"}, 64'(rresp), 64'(eresp));
    tick();
    rready = 1'b0;
  endtask

  task automatic wr1(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                     input logic [3:0] id);
    aw_send(a, id, 2'b01, 8'd0);
    w_beat(d, s, 1'b1);
    b_take(id, 2'b00, "wr1");
  endtask

  task automatic rd1(input logic [31:0] a, input logic [3:0] id, input logic [63:0] ed,
                     input logic [1:0] eresp, input string tag);
    ar_send(a, id, 2'b01, 8'd0);
    r_take(ed, 1'b1, id, eresp, tag);
  endtask

  // Directed sequence.
  initial begin
    // Reset values
    repeat (3) tick();
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_bresp_rresp", 64'({bresp, rresp}), 64'd0);
    chk("rst_bid_rid", 64'({bid, rid}), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    rst_n = 1'b1;
    chk("rel_awready_low", 64'(awready), 64'd0);
    tick();
    chk("rel_awready", 64'(awready), 64'd1);
    chk("rel_arready", 64'(arready), 64'd1);

    // Single-beat write/read at 0x0 with latency checks
    aw_send(32'h0, 4'd0, 2'b01, 8'd0);
    chk("t1_wready_next", 64'(wready), 64'd1);
    w_beat(64'h0123456789ABCDEF, 8'hFF, 1'b1);
    chk("t1_bvalid_next", 64'(bvalid), 64'd1);
    b_take(4'd0, 2'b00, "t1");
    chk("t1_awready_after_b", 64'(awready), 64'd1);
    ar_send(32'h0, 4'd0, 2'b01, 8'd0);
    chk("t1_rvalid_next", 64'(rvalid), 64'd1);
    r_take(64'h0123456789ABCDEF, 1'b1, 4'd0, 2'b00, "t1r");
    chk("t1_arready_after_r", 64'(arready), 64'd1);

    // Byte strobes: low four bytes cleared
    wr1(32'h8, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 4'd1);
    wr1(32'h8, 64'h0, 8'h0F, 4'd1);
    rd1(32'h8, 4'd2, 64'hFFFFFFFF00000000, 2'b00, "t2");

    // INCR burst of four beats, streamed back with RREADY held high
    aw_send(32'h100, 4'd5, 2'b01, 8'd3);
    for (int i = 0; i < 4; i++) w_beat(64'(i + 1), 8'hFF, i == 3);
    b_take(4'd5, 2'b00, "t3");
    ar_send(32'h100, 4'd9, 2'b01, 8'd3);
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_rvalid", 64'(rvalid), 64'd1);
      chk("t3_rdata", rdata, 64'(i + 1));
      chk("t3_rlast", 64'(rlast), 64'(i == 3));
      chk("t3_rid", 64'(rid), 64'd9);
      tick();
    end
    rready = 1'b0;
    chk("t3_rvalid_done", 64'(rvalid), 64'd0);
    chk("t3_arready_done", 64'(arready), 64'd1);

    // High address: aliases to word 0, or DECERR when range checking is on
    wr1(32'h0, 64'hAA, 8'hFF, 4'd0);
`ifdef AXI_CACHE_DECERR_EN
    rd1(32'h80000000, 4'd3, 64'h0, 2'b11, "t4");
    aw_send(32'h80000000, 4'd3, 2'b01, 8'd0);
    w_beat(64'hBB, 8'hFF, 1'b1);
    b_take(4'd3, 2'b11, "t4w");
    rd1(32'h0, 4'd3, 64'hAA, 2'b00, "t4_dropped");
`else
    rd1(32'h80000000, 4'd3, 64'hAA, 2'b00, "t4");
`endif

    // Backpressure on B and R
    aw_send(32'h10, 4'd6, 2'b01, 8'd0);
    w_beat(64'h55, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_bvalid_hold", 64'(bvalid), 64'd1);
      chk("t5_bid_hold", 64'(bid), 64'd6);
      chk("t5_bresp_hold", 64'(bresp), 64'd0);
      chk("t5_awready_low", 64'(awready), 64'd0);
      tick();
    end
    b_take(4'd6, 2'b00, "t5");
    ar_send(32'h10, 4'd7, 2'b01, 8'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_rvalid_hold", 64'(rvalid), 64'd1);
      chk("t5_rdata_hold", rdata, 64'h55);
      chk("t5_rid_hold", 64'(rid), 64'd7);
      chk("t5_rlast_hold", 64'(rlast), 64'd1);
      chk("t5_arready_low", 64'(arready), 64'd0);
      tick();
    end
    r_take(64'h55, 1'b1, 4'd7, 2'b00, "t5r");

    // WLAST on the wrong beat gives SLVERR; both beats still land
    aw_send(32'h20, 4'd2, 2'b01, 8'd1);
    w_beat(64'h11, 8'hFF, 1'b1);
    w_beat(64'h22, 8'hFF, 1'b0);
    b_take(4'd2, 2'b10, "t6");
    rd1(32'h28, 4'd2, 64'h22, 2'b00, "t6r");

    // FIXED burst: every beat hits the same word, last one wins
    aw_send(32'h200, 4'd1, 2'b00, 8'd2);
    w_beat(64'h7, 8'hFF, 1'b0);
    w_beat(64'h8, 8'hFF, 1'b0);
    w_beat(64'h9, 8'hFF, 1'b1);
    b_take(4'd1, 2'b00, "t7");
    rd1(32'h200, 4'd1, 64'h9, 2'b00, "t7r");

    // Reset in the middle of a read burst; memory survives
    ar_send(32'h100, 4'd4, 2'b01, 8'd3);
    rready = 1'b1;
    tick();
    chk("t8_beat2", rdata, 64'h2);
    rst_n = 1'b0;
    #1;
    chk("t8_rvalid_rst", 64'(rvalid), 64'd0);
    chk("t8_arready_rst", 64'(arready), 64'd0);
    chk("t8_rdata_rst", rdata, 64'd0);
    rready = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t8_arready_rel", 64'(arready), 64'd0);
    tick();
    chk("t8_arready_after", 64'(arready), 64'd1);
    rd1(32'h108, 4'd4, 64'h2, 2'b00, "t8_mem_kept");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
